// File: rtl/sal_rdata_merger_if.sv
// Bank-side read-data beats plus the AXI R channel seen by the read-data merger.
// master = merger side, slave = bank controllers / AXI consumer side.
interface sal_rdata_merger_if #(
    parameter int BK_CNT = 8,
    parameter int ID_W   = 4,
    parameter int DATA_W = 64
);
    logic [BK_CNT-1:0]        bk_rvalid;
    logic [BK_CNT*ID_W-1:0]   bk_rid;
    logic [BK_CNT*DATA_W-1:0] bk_rdata;
    logic [BK_CNT-1:0]        bk_rlast;
    logic [BK_CNT-1:0]        bk_rready;

    logic                     rvalid;
    logic                     rready;
    logic [ID_W-1:0]          rid;
    logic [DATA_W-1:0]        rdata;
    logic [1:0]               rresp;
    logic                     rlast;

    modport master (
        input  bk_rvalid, bk_rid, bk_rdata, bk_rlast, rready,
        output bk_rready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        output bk_rvalid, bk_rid, bk_rdata, bk_rlast, rready,
        input  bk_rready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/sal_rdata_merger.sv
// Merges per-bank read bursts onto the AXI R channel, round-robin at burst granularity; 1-cycle latency.
// Backpressure: rready only drains a 2-entry output buffer; bank ready drops when that buffer is full.
module sal_rdata_merger #(
    parameter int BK_CNT = 8,
    parameter int ID_W   = 4,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    sal_rdata_merger_if.master  bus
);
    localparam int GW = (BK_CNT > 1) ? $clog2(BK_CNT) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   grant, last_grant, pick, cand;
    logic            any_vld;
    logic [1:0]      cnt;
    beat_t           head, tail, in_beat;
    logic            can_take, push, pop;
    logic [BK_CNT-1:0] rdy;

    // First requesting bank strictly after the previous winner, with wrap.
    always_comb begin
        pick    = last_grant;
        cand    = last_grant;
        any_vld = 1'b0;
        for (int i = 1; i <= BK_CNT; i++) begin
            cand = GW'((int'(last_grant) + i) % BK_CNT);
            if (!any_vld && bus.bk_rvalid[cand]) begin
                any_vld = 1'b1;
                pick    = cand;
            end
        end
    end

    // Ready comes only from registered state so rready never reaches a bank.
    assign can_take = (state == BURST) && (cnt != 2'd2);
    assign push     = can_take && bus.bk_rvalid[grant];
    assign pop      = (cnt != 2'd0) && bus.rready;

    always_comb begin
        rdy = '0;
        if (can_take) begin
            rdy[grant] = 1'b1;
        end
    end
    assign bus.bk_rready = rdy;

    assign in_beat.id   = bus.bk_rid[int'(grant)*ID_W +: ID_W];
    assign in_beat.data = bus.bk_rdata[int'(grant)*DATA_W +: DATA_W];
    assign in_beat.last = bus.bk_rlast[grant];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_vld) state_nxt = BURST;
            BURST:   if (push && in_beat.last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(BK_CNT - 1);
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_vld) begin
                grant      <= pick;
                last_grant <= pick;
            end
        end
    end

    // Shift-style buffer: head is always the oldest beat and keeps its value once drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) head <= in_beat;
                    else             tail <= in_beat;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    if (cnt == 2'd2) head <= tail;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        head <= in_beat;
                    end else begin
                        head <= tail;
                        tail <= in_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rvalid = (cnt != 2'd0);
    assign bus.rid    = head.id;
    assign bus.rdata  = head.data;
    assign bus.rlast  = head.last;
    assign bus.rresp  = 2'b00;
endmodule

// File: tb/tb_sal_rdata_merger.sv
// Randomized and directed bench for sal_rdata_merger; bank drivers plus a queue-based round-robin reference.
module tb_sal_rdata_merger;
    localparam int BK = 8;
    localparam int IW = 4;
    localparam int DW = 64;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk;
    logic rst;

    sal_rdata_merger_if #(.BK_CNT(BK), .ID_W(IW), .DATA_W(DW)) bus ();

    sal_rdata_merger #(.BK_CNT(BK), .ID_W(IW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t bank_q [BK][$];
    beat_t mdl_q  [BK][$];
    beat_t exp_q  [$];
    int    out_cyc[$];
    bit    mid    [BK];
    int    mdl_last;
    int    cyc;
    int    first_hs;
    int    rready_mode;
    bit    gap_en;
    bit    hold_vld;
    logic [IW+DW:0] held;
    int    nvec;
    int    nerr;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit pending();
        for (int b = 0; b < BK; b++)
            if (bank_q[b].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load_burst(input int b, input int len, input logic [IW-1:0] id,
                              input logic [DW-1:0] base, input bit rnd);
        beat_t e;
        for (int k = 0; k < len; k++) begin
            e.id   = id;
            e.data = rnd ? {$urandom(), $urandom()} : base + DW'(k);
            e.last = (k == len - 1);
            bank_q[b].push_back(e);
            mdl_q[b].push_back(e);
        end
    endtask

    // Reference: whole bursts in round-robin order over banks that still hold bursts.
    task automatic model_bursts(input int n);
        int    done;
        int    c;
        beat_t e;
        done = 0;
        while (n < 0 || done < n) begin
            c = -1;
            for (int i = 1; i <= BK; i++) begin
                if (c < 0 && mdl_q[(mdl_last + i) % BK].size() > 0) c = (mdl_last + i) % BK;
            end
            if (c < 0) break;
            do begin
                e = mdl_q[c].pop_front();
                exp_q.push_back(e);
            end while (!e.last);
            mdl_last = c;
            done++;
        end
    endtask

    task automatic drive();
        case (rready_mode)
            0:       bus.rready = 1'b1;
            1:       bus.rready = ($urandom_range(3) != 0);
            default: bus.rready = 1'b0;
        endcase
        for (int b = 0; b < BK; b++) begin
            if (bank_q[b].size() > 0 && !(gap_en && mid[b] && $urandom_range(2) == 0)) begin
                bus.bk_rvalid[b]            = 1'b1;
                bus.bk_rid[b*IW +: IW]      = bank_q[b][0].id;
                bus.bk_rdata[b*DW +: DW]    = bank_q[b][0].data;
                bus.bk_rlast[b]             = bank_q[b][0].last;
            end else begin
                bus.bk_rvalid[b]            = 1'b0;
                bus.bk_rid[b*IW +: IW]      = '0;
                bus.bk_rdata[b*DW +: DW]    = '0;
                bus.bk_rlast[b]             = 1'b0;
            end
        end
    endtask

    // Sample at negedge (inputs and registered outputs are settled), then drive #1 after posedge.
    task automatic cycle();
        logic [BK-1:0] hs;
        beat_t e;
        @(negedge clk);
        cyc++;
        hs = bus.bk_rvalid & bus.bk_rready;
        chk("rdy_onehot", ($countones(bus.bk_rready) <= 1), 1);
        if (hold_vld) chk("r_stable", {bus.rvalid, bus.rid, bus.rdata, bus.rlast}, {1'b1, held});
        hold_vld = bus.rvalid && !bus.rready;
        held     = {bus.rid, bus.rdata, bus.rlast};
        if (bus.rvalid && bus.rready) begin
            chk("rresp", bus.rresp, 0);
            chk("beat_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rbeat", {bus.rid, bus.rdata, bus.rlast}, {e.id, e.data, e.last});
            end
            out_cyc.push_back(cyc);
        end
        for (int b = 0; b < BK; b++) begin
            if (hs[b] && bank_q[b].size() > 0) begin
                if (first_hs < 0) first_hs = cyc;
                mid[b] = !bank_q[b][0].last;
                void'(bank_q[b].pop_front());
            end
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic clear_all();
        for (int b = 0; b < BK; b++) begin
            bank_q[b].delete();
            mdl_q[b].delete();
            mid[b] = 1'b0;
        end
        exp_q.delete();
        out_cyc.delete();
        hold_vld = 1'b0;
        mdl_last = BK - 1;
        first_hs = -1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.rready    = 1'b0;
        bus.bk_rvalid = '0;
        clear_all();
        @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_bk_rready", bus.bk_rready, 0);
        chk("rst_payload", {bus.rid, bus.rdata, bus.rlast}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || pending()) && n < max) begin
            cycle();
            n++;
        end
        chk("drain_done", (n < max), 1);
        repeat (4) cycle();
    endtask

    initial begin
        int n;
        nvec = 0; nerr = 0; cyc = 0;
        rready_mode = 0; gap_en = 1'b0;
        bus.bk_rvalid = '0; bus.bk_rid = '0; bus.bk_rdata = '0; bus.bk_rlast = '0;
        bus.rready = 1'b0;
        rst = 1'b1;

        // Single burst: ordering, rlast placement, 1-cycle latency.
        do_reset();
        load_burst(3, 4, 4'd5, 64'hA0, 1'b0);
        model_bursts(-1);
        drive();
        drain(100);
        chk("latency", (out_cyc.size() > 0) ? out_cyc[0] - first_hs : -1, 1);
        chk("beat_count", out_cyc.size(), 4);

        // Two contenders after reset: bank 1 burst fully before bank 5.
        do_reset();
        load_burst(1, 2, 4'd1, 64'h10, 1'b0);
        load_burst(5, 2, 4'd5, 64'h50, 1'b0);
        model_bursts(-1);
        drive();
        drain(100);

        // Output stall fills the buffer; bank ready must drop and nothing is lost.
        do_reset();
        load_burst(0, 8, 4'd0, 64'h100, 1'b0);
        model_bursts(-1);
        drive();
        n = 0;
        while (out_cyc.size() < 1 && n < 50) begin cycle(); n++; end
        chk("stall_start", (n < 50), 1);
        rready_mode = 2;
        bus.rready  = 1'b0;
        repeat (5) cycle();
        chk("stall_bk_rready", bus.bk_rready, 0);
        chk("stall_rvalid", bus.rvalid, 1);
        rready_mode = 0;
        drive();
        drain(100);
        chk("stall_beats", out_cyc.size(), 8);

        // Banks 0,1,2 busy; bank 7 joins during the first burst and is served after bank 2.
        do_reset();
        for (int k = 0; k < 3; k++)
            for (int b = 0; b < 3; b++)
                load_burst(b, 2, IW'(b), DW'(b * 256 + k * 16), 1'b0);
        model_bursts(1);
        drive();
        n = 0;
        while (first_hs < 0 && n < 50) begin cycle(); n++; end
        chk("rr_first_hs", (n < 50), 1);
        load_burst(7, 2, 4'd7, 64'h700, 1'b0);
        model_bursts(-1);
        drive();
        drain(300);

        // Reset mid-burst: no residual beats, bank 0 first afterwards.
        do_reset();
        load_burst(2, 4, 4'd2, 64'h200, 1'b0);
        model_bursts(-1);
        drive();
        n = 0;
        while (bank_q[2].size() > 2 && n < 50) begin cycle(); n++; end
        chk("midburst_reached", bank_q[2].size(), 2);
        do_reset();
        load_burst(0, 2, 4'd0, 64'h300, 1'b0);
        load_burst(4, 2, 4'd4, 64'h340, 1'b0);
        model_bursts(-1);
        drive();
        drain(100);

        // Back-to-back bursts: exactly one bubble on the output.
        do_reset();
        load_burst(2, 4, 4'd2, 64'h20, 1'b0);
        load_burst(6, 4, 4'd6, 64'h60, 1'b0);
        model_bursts(-1);
        drive();
        drain(100);
        chk("b2b_count", out_cyc.size(), 8);
        if (out_cyc.size() == 8) begin
            chk("b2b_first_run", out_cyc[3] - out_cyc[0], 3);
            chk("b2b_bubble", out_cyc[4] - out_cyc[3], 2);
            chk("b2b_second_run", out_cyc[7] - out_cyc[4], 3);
        end

        // Random bursts, random valid gaps and random rready.
        gap_en = 1'b1;
        rready_mode = 1;
        for (int r = 0; r < 6; r++) begin
            for (int b = 0; b < BK; b++) begin
                int nb;
                nb = $urandom_range(2);
                for (int k = 0; k < nb; k++)
                    load_burst(b, $urandom_range(4, 1), IW'($urandom), '0, 1'b1);
            end
            model_bursts(-1);
            drive();
            drain(3000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/sal_rdata_merger.md
Name: sal_rdata_merger

Overview:
- Return-path counterpart of the request address decoder.
- Collects read-data bursts from the per-bank controllers and returns them to the AXI read-data (R) channel.
- Arbitrates round-robin among banks at burst granularity, so beats from different bursts never interleave.
- Drives the R channel from a 2-entry output buffer, so rready never combinationally reaches any bank.

Parameters:
- BK_CNT, 8: number of bank controllers (DRAM bank count).
- ID_W, 4: AXI ID width.
- DATA_W, 64: data beat width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- bk_rvalid  input  BK_CNT  per-bank beat valid.
- bk_rid  input  BK_CNT*ID_W  per-bank ID; bank i occupies bits [i*ID_W +: ID_W].
- bk_rdata  input  BK_CNT*DATA_W  per-bank data, packed the same way.
- bk_rlast  input  BK_CNT  per-bank last beat of burst.
- bk_rready  output  BK_CNT  per-bank beat accept.
- rvalid  output  1  AXI R valid.
- rready  input  1  AXI R ready.
- rid  output  ID_W  AXI R ID.
- rdata  output  DATA_W  AXI R data.
- rresp  output  2  AXI R response; constant 2'b00 (OKAY).
- rlast  output  1  AXI R last.

Behaviour:
- Reset (rst=1 at a clk edge), taking effect on the next cycle:
  - state=IDLE.
  - Buffer emptied (cnt=0); rvalid=0; rid, rdata, rlast = 0.
  - bk_rready=0.
  - last_grant=BK_CNT-1, so bank 0 has first priority.
  - An in-flight burst is abandoned. No residual beats are emitted after reset.
- FSM states: IDLE, BURST. Registers: grant (index), last_grant, cnt (0..2).
- IDLE:
  - If any bk_rvalid is set, select the first set bit scanning from (last_grant+1) mod BK_CNT upward with wrap-around.
  - Register the choice into grant and last_grant; next state BURST.
  - If no bk_rvalid is set, stay in IDLE.
  - bk_rready=0 in IDLE.
- BURST:
  - bk_rready[grant] = (cnt<2); all other bits are 0.
  - cnt is a register, so bk_rready depends only on state, grant and cnt.
  - A beat is accepted when bk_rvalid[grant] and bk_rready[grant] are both high. It pushes {bk_rid, bk_rdata, bk_rlast} of bank grant into the buffer.
  - An accepted beat with rlast=1 sends next state to IDLE. Other banks' valids are ignored until then.
- Handoff cost: one IDLE cycle between consecutive bursts on the input side.
- Buffer (2-entry FIFO):
  - Head entry drives rid, rdata, rlast; rvalid = (cnt!=0).
  - Pop when rvalid and rready are both high.
  - Push and pop in the same cycle leave cnt unchanged and preserve order.
  - Full (cnt=2) deasserts bk_rready on the following cycle decision; no overflow is possible.
  - Empty: rvalid=0, and the payload holds its last value.
- Latency: a beat accepted at edge t is visible on rvalid/rdata after edge t, i.e. 1 cycle.
- Throughput: with rready held high, 1 beat/cycle within a burst.
- AXI rules:
  - Once rvalid=1, it and the payload stay stable until rready=1.
  - Beats leave in acceptance order.
- Out of scope: burst length is not checked. A bank holding bk_rvalid without ever sending rlast keeps the grant indefinitely (bank controller responsibility).
- Simultaneous events:
  - A bank raising valid in the same cycle as the IDLE decision is eligible.
  - A bank raising valid during BURST waits for the next IDLE.

Test Plan:
- Bank 3 sends a 4-beat burst, rid=5, data 0xA0..0xA3, rready=1 → four R beats, rid=5, data in order, rlast only on 0xA3; first rvalid exactly 1 cycle after the first bk_rready&bk_rvalid.
- After reset, banks 1 and 5 both valid, 2-beat bursts each → all bank-1 beats, then all bank-5 beats; no interleave; rresp=0 throughout.
- Bank 0, 8-beat burst; rready=0 for 5 cycles starting at beat 2 → cnt reaches 2, bk_rready[0]=0 while full; all 8 beats delivered exactly once, in order; payload stable while stalled.
- Banks 0, 1, 2 continuously valid with 2-beat bursts → grant sequence 0,1,2,0,1,2; bank 7 joining later is served once the scan wraps past it.
- rst asserted during beat 2 of a 4-beat burst → next cycle rvalid=0 and bk_rready all 0; after release with banks 0 and 4 valid, bank 0 is granted first.
- Two back-to-back 4-beat bursts (banks 2 and 6), rready=1 → 8 output beats with exactly one bubble cycle between bursts.
